// File: rtl/axi_lite_master_if.sv
//============================================================================
// Module      : axi_lite_master_if
// Description : Bundle of the local command/response handshake and the five
//               AXI4-Lite channels seen by axi_lite_master. The master modport
//               is the view of the master itself; the slave modport is the
//               view of whatever sits on the other side (host + AXI slave).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface axi_lite_master_if #(
    parameter int P_M_AXI_DATA_WIDTH = 32,
    parameter int P_M_AXI_ADDR_WIDTH = 4
);
    // Local command side
    logic                              cmd_valid;
    logic                              cmd_ready;
    logic                              cmd_write;
    logic [P_M_AXI_ADDR_WIDTH-1:0]     cmd_addr;
    logic [P_M_AXI_DATA_WIDTH-1:0]     cmd_wdata;
    logic [P_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb;

    // Local response side
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic                              rsp_write;
    logic [P_M_AXI_DATA_WIDTH-1:0]     rsp_rdata;
    logic [1:0]                        rsp_resp;
    logic [7:0]                        err_cnt;

    // Write address channel
    logic [P_M_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                        awprot;
    logic                              awvalid;
    logic                              awready;

    // Write data channel
    logic [P_M_AXI_DATA_WIDTH-1:0]     wdata;
    logic [P_M_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;

    // Write response channel
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;

    // Read address channel
    logic [P_M_AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                        arprot;
    logic                              arvalid;
    logic                              arready;

    // Read data channel
    logic [P_M_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_cnt,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_master.sv
//============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI4-Lite master. Converts one local
//               command (write or read) into an AXI-Lite transaction, returns
//               the slave's response on the local response handshake and
//               keeps a saturating count of non-OKAY responses. All outputs
//               are registered.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_lite_master #(
    parameter int P_M_AXI_DATA_WIDTH = 32,
    parameter int P_M_AXI_ADDR_WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axi_lite_master_if.master  bus
);

    localparam int c_STRB_WIDTH = P_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                          r_state;
    logic                            r_cmd_ready;
    logic [P_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [P_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_WIDTH-1:0]         r_wstrb;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic                            r_bready;
    logic                            r_arvalid;
    logic                            r_rready;
    logic                            r_rsp_valid;
    logic                            r_rsp_write;
    logic [P_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                      r_rsp_resp;
    logic [7:0]                      r_err_cnt;

    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_aw_all;
    logic                            w_w_all;
    logic                            w_err_room;

    // AW and W handshakes complete independently; the write request phase
    // is over once both have happened, in this cycle or an earlier one.
    assign w_aw_hs    = r_awvalid & bus.awready;
    assign w_w_hs     = r_wvalid  & bus.wready;
    assign w_aw_all   = r_aw_done | w_aw_hs;
    assign w_w_all    = r_w_done  | w_w_hs;
    assign w_err_room = (r_err_cnt != 8'hFF);

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.awaddr    = r_addr;
    assign bus.awprot    = 3'b000;
    assign bus.awvalid   = r_awvalid;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;
    assign bus.wvalid    = r_wvalid;
    assign bus.bready    = r_bready;
    assign bus.araddr    = r_addr;
    assign bus.arprot    = 3'b000;
    assign bus.arvalid   = r_arvalid;
    assign bus.rready    = r_rready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;
    assign bus.err_cnt   = r_err_cnt;

    // Transaction state machine with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_err_cnt   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is raised here after reset, so a command can
                    // only be taken once the ready the host sees is high.
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= bus.cmd_addr;
                        r_wdata     <= bus.cmd_wdata;
                        r_wstrb     <= bus.cmd_wstrb;
                        if (bus.cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_WR_RESP;
                    end else begin
                        r_aw_done <= w_aw_all;
                        r_w_done  <= w_w_all;
                    end
                end

                S_WR_RESP: begin
                    if (bus.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= bus.bresp;
                        if ((bus.bresp != 2'b00) && w_err_room) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= S_RSP;
                    end
                end

                S_RD_REQ: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (bus.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= bus.rdata;
                        r_rsp_resp  <= bus.rresp;
                        if ((bus.rresp != 2'b00) && w_err_room) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
